writeback_stage: RTL
====================

Name: writeback_stage

Overview:
- Final stage of the multi-cycle RISC-V datapath; the writer side of the register bank interface.
- Accepts one retired instruction result from execute via a valid/ready handshake.
- For loads, issues a word read to data memory, waits for the acknowledge, then aligns and sign-/zero-extends the data.
- Drives rd, wb_data and save_to_reg for exactly one stage_clk cycle per writing instruction.

Parameters:
- XLEN, 32, datapath width.
- MEM_TIMEOUT, 16, maximum cycles in MEM_WAIT before a load fault is raised (must be >= 2).

Ports:
- stage_clk  in  1  stage clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  execute presents a result.
- in_ready  out  1  stage can accept; high only in IDLE.
- in_rd  in  5  destination register.
- in_alu_result  in  XLEN  ALU result; the effective address for loads.
- in_pc_plus4  in  XLEN  return address for JAL/JALR.
- in_wb_sel  in  2  00 ALU, 01 MEM, 10 PC4, 11 NONE.
- in_funct3  in  3  load size/sign code.
- mem_req  out  1  read request, held until ack.
- mem_addr  out  XLEN  word-aligned address, bits [1:0] = 0.
- mem_rdata  in  XLEN  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle read completion.
- rd  out  5  register bank write index.
- wb_data  out  XLEN  register bank write data.
- save_to_reg  out  1  register bank write enable.
- load_fault  out  1  one-cycle pulse on misaligned, illegal or timed-out load.

Behaviour:
- Reset (asynchronous, active-high; clock stage_clk): state IDLE; in_ready=1; mem_req=0; mem_addr=0; rd=0; wb_data=0; save_to_reg=0; load_fault=0; timeout counter=0; captured fields=0.
- States: IDLE, MEM_WAIT, WRITE, FAULT.
- IDLE:
  - in_valid high at an edge captures rd, alu_result, pc_plus4, wb_sel and funct3.
  - wb_sel ALU, PC4 or NONE -> WRITE.
  - wb_sel MEM with a legal, aligned load -> MEM_WAIT, with mem_req=1 and mem_addr={alu_result[31:2],2'b00} registered on the same edge.
  - wb_sel MEM that is illegal or misaligned -> FAULT.
- Legal funct3 codes: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Codes 011, 110 and 111 are illegal.
- Misalignment rules: LH/LHU with addr[0]=1; LW with addr[1:0]!=00. Byte loads are never misaligned.
- MEM_WAIT:
  - mem_req and mem_addr are held stable.
  - The counter increments each cycle.
  - mem_ack high: capture the aligned/extended data, drop mem_req, go to WRITE.
  - Counter reaches MEM_TIMEOUT-1 without ack: drop mem_req, go to FAULT.
  - If ack and timeout coincide, ack wins.
- Data extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- WRITE (one cycle):
  - save_to_reg=1, rd=captured rd, wb_data=selected value.
  - save_to_reg is forced to 0 when rd==0 or wb_sel==NONE; rd and wb_data are still driven.
  - Next state is IDLE.
- FAULT (one cycle): load_fault=1, save_to_reg=0, next state IDLE. No register write for the faulting instruction.
- save_to_reg, rd and wb_data are registered outputs. They are valid throughout the WRITE cycle; the register bank captures them on the edge that ends WRITE.
- Latency from the accept edge N:
  - Non-load: save_to_reg high in cycle N+1.
  - Load with ack in the k-th MEM_WAIT cycle: save_to_reg high in cycle N+k+1.
- in_ready=0 in every state except IDLE. in_valid outside IDLE is ignored; execute must hold it.
- mem_ack outside MEM_WAIT is ignored.
- Reset mid-operation: immediate return to IDLE, mem_req dropped asynchronously, no write and no fault pulse.
- Throughput: one instruction per 2 cycles minimum (IDLE, WRITE).

Decomposition:
- Shared package rv_pkg:
  - WB_ALU/WB_MEM/WB_PC4/WB_NONE encodings.
  - Load funct3 constants LB/LH/LW/LBU/LHU.
  - State encoding for this FSM.
  - XLEN default.
- One combinational sub-module, load_align:
  - Inputs: funct3, addr[1:0], mem_rdata.
  - Outputs: extended data, misaligned flag, illegal flag.
  - The misaligned/illegal flags are used in IDLE on in_funct3/in_alu_result; the data is used on ack.

Test Plan:
- ALU writeback: in_rd=5, in_wb_sel=00, in_alu_result=0x0000_1234 -> in_ready low for 1 cycle; save_to_reg=1, rd=5, wb_data=0x0000_1234 for exactly one cycle; then IDLE.
- x0 / NONE suppression: in_rd=0 with wb_sel=00, then in_rd=7 with wb_sel=11 -> save_to_reg stays 0 for both; in_ready returns high after each.
- LB sign-extend: funct3=000, addr=0x103, ack after 3 cycles with mem_rdata=0x80AA_BBCC:
  - mem_addr=0x100 and mem_req held 3 cycles.
  - wb_data=0xFFFF_FF80.
  - Repeat with LBU -> 0x0000_0080.
- Misaligned/illegal loads: LW at 0x102, LH at 0x101, funct3=011 -> load_fault one-cycle pulse each; mem_req never asserted; save_to_reg=0.
- Timeout: LW at 0x200, mem_ack never asserted -> mem_req high for MEM_TIMEOUT cycles, then load_fault pulse, no write. Ack on the final cycle -> normal write, no fault.
- Reset mid-load: assert reset during MEM_WAIT -> mem_req=0 immediately, outputs at reset values, no save_to_reg or load_fault. A later ALU instruction completes normally.

Source files
------------

// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the multi-cycle RISC-V datapath.
// Contents:
//   XLEN_DEFAULT       default datapath width
//   WB_*               writeback source select encodings (in_wb_sel)
//   F3_*               load size/sign codes (funct3 of LOAD instructions)
//   wb_state_e         writeback stage FSM state encoding
// ----------------------------------------------------------------------------
package rv_pkg;

   localparam int XLEN_DEFAULT = 32;

   // Writeback source select
   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_MEM  = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;
   localparam logic [1:0] WB_NONE = 2'b11;

   // Load funct3 codes; 011, 110 and 111 are not loads
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_MEM_WAIT = 2'b01,
      ST_WRITE    = 2'b10,
      ST_FAULT    = 2'b11
   } wb_state_e;

endpackage : rv_pkg

// File: rtl/load_align.sv
// ----------------------------------------------------------------------------
// load_align
// Combinational load decoder: picks the byte/half/word lane out of a read
// word, sign- or zero-extends it, and flags illegal or misaligned accesses.
// Ports:
//   funct3_i       load size/sign code
//   addr_lo_i      low two bits of the effective address
//   mem_rdata_i    full word returned by data memory
//   data_o         aligned and extended load result
//   misaligned_o   half not on a 2-byte boundary, or word not on 4
//   illegal_o      funct3 is not a load code
// ----------------------------------------------------------------------------
module load_align
   import rv_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      addr_lo_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   output logic [XLEN-1:0] data_o,
   output logic            misaligned_o,
   output logic            illegal_o
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Byte lane is addr[1:0]; half lane is addr[1] only, addr[0] is the
   // misalignment bit for halves.
   assign byte_lane = mem_rdata_i[{addr_lo_i, 3'b000} +: 8];
   assign half_lane = mem_rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      data_o       = '0;
      misaligned_o = 1'b0;
      illegal_o    = 1'b0;
      case (funct3_i)
         F3_LB:  data_o = {{(XLEN-8){byte_lane[7]}}, byte_lane};
         F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_lane};
         F3_LH: begin
            data_o       = {{(XLEN-16){half_lane[15]}}, half_lane};
            misaligned_o = addr_lo_i[0];
         end
         F3_LHU: begin
            data_o       = {{(XLEN-16){1'b0}}, half_lane};
            misaligned_o = addr_lo_i[0];
         end
         F3_LW: begin
            data_o       = mem_rdata_i;
            misaligned_o = |addr_lo_i;
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule : load_align

// File: rtl/writeback_stage.sv
// ----------------------------------------------------------------------------
// writeback_stage
// Final stage of the multi-cycle datapath and writer side of the register
// bank. Accepts one retired result from execute, performs the data-memory
// read for loads, and presents one register-bank write per instruction.
// Ports:
//   stage_clk, reset        clock (rising edge), async active-high reset
//   in_valid / in_ready     execute handshake; ready only while idle
//   in_rd                   destination register
//   in_alu_result           ALU result, effective address for loads
//   in_pc_plus4             link value for JAL/JALR
//   in_wb_sel               writeback source (ALU, MEM, PC4, NONE)
//   in_funct3               load size/sign code
//   mem_req / mem_addr      word read request, held until mem_ack
//   mem_rdata / mem_ack     read data, valid on the one-cycle ack
//   rd / wb_data            register bank write index and data
//   save_to_reg             register bank write enable (one cycle)
//   load_fault              one-cycle pulse on bad or timed-out load
// ----------------------------------------------------------------------------
module writeback_stage
   import rv_pkg::*;
#(
   parameter int XLEN        = XLEN_DEFAULT,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic            stage_clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      in_rd,
   input  logic [XLEN-1:0] in_alu_result,
   input  logic [XLEN-1:0] in_pc_plus4,
   input  logic [1:0]      in_wb_sel,
   input  logic [2:0]      in_funct3,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ack,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] wb_data,
   output logic            save_to_reg,
   output logic            load_fault
);

   localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   wb_state_e         state_q;
   logic [CNT_W-1:0]  cnt_q;

   // Fields captured at accept that the load path still needs after IDLE
   logic [4:0]        cap_rd_q;
   logic [2:0]        cap_funct3_q;
   logic [1:0]        cap_addr_lo_q;

   // Registered outputs
   logic              mem_req_q;
   logic [XLEN-1:0]   mem_addr_q;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   wb_data_q;
   logic              save_q;
   logic              fault_q;

   // Single decoder instance: checks the incoming instruction while idle and
   // extracts the captured load's data while waiting for the ack.
   logic [2:0]        la_funct3;
   logic [1:0]        la_addr_lo;
   logic [XLEN-1:0]   la_data;
   logic              la_misaligned;
   logic              la_illegal;

   assign la_funct3  = (state_q == ST_IDLE) ? in_funct3           : cap_funct3_q;
   assign la_addr_lo = (state_q == ST_IDLE) ? in_alu_result[1:0]  : cap_addr_lo_q;

   load_align #(
      .XLEN (XLEN)
   ) u_load_align (
      .funct3_i     (la_funct3),
      .addr_lo_i    (la_addr_lo),
      .mem_rdata_i  (mem_rdata),
      .data_o       (la_data),
      .misaligned_o (la_misaligned),
      .illegal_o    (la_illegal)
   );

   always_ff @(posedge stage_clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         cap_rd_q      <= '0;
         cap_funct3_q  <= '0;
         cap_addr_lo_q <= '0;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= '0;
         rd_q          <= '0;
         wb_data_q     <= '0;
         save_q        <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         // NOTE: all state here uses non-blocking assignment so every flop
         // samples pre-edge values regardless of statement order.
         save_q  <= 1'b0;
         fault_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  cap_rd_q      <= in_rd;
                  cap_funct3_q  <= in_funct3;
                  cap_addr_lo_q <= in_alu_result[1:0];
                  if (in_wb_sel == WB_MEM) begin
                     if (la_illegal || la_misaligned) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                     end else begin
                        state_q    <= ST_MEM_WAIT;
                        cnt_q      <= '0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {in_alu_result[XLEN-1:2], 2'b00};
                     end
                  end else begin
                     // Non-load results are written on the very next cycle
                     state_q   <= ST_WRITE;
                     rd_q      <= in_rd;
                     wb_data_q <= (in_wb_sel == WB_PC4) ? in_pc_plus4 : in_alu_result;
                     save_q    <= (in_rd != 5'd0) && (in_wb_sel != WB_NONE);
                  end
               end
            end

            ST_MEM_WAIT: begin
               // Ack is tested first so it wins over a coinciding timeout
               if (mem_ack) begin
                  state_q   <= ST_WRITE;
                  mem_req_q <= 1'b0;
                  rd_q      <= cap_rd_q;
                  wb_data_q <= la_data;
                  save_q    <= (cap_rd_q != 5'd0);
               end else if (cnt_q == CNT_LAST) begin
                  state_q   <= ST_FAULT;
                  mem_req_q <= 1'b0;
                  fault_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            ST_WRITE: state_q <= ST_IDLE;
            ST_FAULT: state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready    = (state_q == ST_IDLE);
   assign mem_req     = mem_req_q;
   assign mem_addr    = mem_addr_q;
   assign rd          = rd_q;
   assign wb_data     = wb_data_q;
   assign save_to_reg = save_q;
   assign load_fault  = fault_q;

endmodule : writeback_stage
